// File: rtl/codec_cmm_sad_search_ctrl.sv
// Candidate-search scheduler for one shared SAD engine: streams H row reads per
// candidate, delays them into the engine's input_vld and keeps the running minimum SAD.
module codec_cmm_sad_search_ctrl #(
  parameter int DW       = 8,
  parameter int W        = 8,
  parameter int H        = 8,
  parameter int MAX_CAND = 64,
  parameter int RD_LAT   = 1,
  parameter int SW       = DW + $clog2(W * H),
  parameter int CIW      = $clog2(MAX_CAND),
  parameter int CNW      = CIW + 1,
  parameter int RW       = $clog2(H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CNW-1:0] num_cand,
  input  logic           abort,
  input  logic           stall,
  output logic           busy,
  output logic           rd_en,
  output logic [CIW-1:0] rd_cand,
  output logic [RW-1:0]  rd_row,
  output logic           sad_in_vld,
  input  logic           sad_vld,
  input  logic [SW-1:0]  sad,
  output logic           done,
  output logic [SW-1:0]  best_sad,
  output logic [CIW-1:0] best_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [CNW-1:0]  n_cand;
  logic [CNW-1:0]  cand_cnt;
  logic [CNW-1:0]  res_cnt;
  logic [RW-1:0]   row;
  logic            abort_pend;
  logic [RD_LAT-1:0] vld_sr;
  logic [CNW-1:0]  n_clip;
  logic            last_row;

  assign n_clip     = (num_cand > CNW'(MAX_CAND)) ? CNW'(MAX_CAND) : num_cand;
  assign rd_en      = (state == ISSUE) && !stall;
  assign rd_cand    = cand_cnt[CIW-1:0];
  assign rd_row     = row;
  assign sad_in_vld = vld_sr[RD_LAT-1];
  assign last_row   = (row == RW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_sad   <= '0;
      best_idx   <= '0;
      n_cand     <= '0;
      cand_cnt   <= '0;
      res_cnt    <= '0;
      row        <= '0;
      abort_pend <= 1'b0;
      vld_sr     <= '0;
    end else begin
      done <= 1'b0;

      // The delay line runs in every state so rows already requested still reach the engine.
      vld_sr[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];

      if (busy && sad_vld) begin
        res_cnt <= res_cnt + 1'b1;
        if (res_cnt == '0 || sad < best_sad) begin
          best_sad <= sad;
          best_idx <= res_cnt[CIW-1:0];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            n_cand     <= n_clip;
            row        <= '0;
            cand_cnt   <= '0;
            res_cnt    <= '0;
            abort_pend <= 1'b0;
            busy       <= 1'b1;
            if (n_clip == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              best_sad <= '1;
              best_idx <= '0;
            end else begin
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (abort) abort_pend <= 1'b1;
          // An abort only takes effect at a candidate boundary to keep engine row framing intact.
          if (rd_en) begin
            if (last_row) begin
              row      <= '0;
              cand_cnt <= cand_cnt + 1'b1;
              if (cand_cnt + 1'b1 == n_cand || abort_pend || abort) state <= DRAIN;
            end else begin
              row <= row + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (abort) abort_pend <= 1'b1;
          if (res_cnt == cand_cnt) begin
            if (abort_pend || abort) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cmm_sad_search_ctrl.sv
// Randomized bench for codec_cmm_sad_search_ctrl: emulates the SAD engine and checks
// request order, delay-line timing and minimum selection against a plain list model.
module tb_codec_cmm_sad_search_ctrl;

  localparam int DW = 8, W = 8, H = 8, MAX_CAND = 64, RD_LAT = 3;
  localparam int SW = DW + $clog2(W * H);
  localparam int CIW = $clog2(MAX_CAND);
  localparam int CNW = CIW + 1;
  localparam int RW = $clog2(H);

  logic           clk = 1'b0;
  logic           rst, start, abort, stall, sad_vld;
  logic [CNW-1:0] num_cand;
  logic [SW-1:0]  sad;
  logic           busy, rd_en, sad_in_vld, done;
  logic [CIW-1:0] rd_cand, best_idx;
  logic [RW-1:0]  rd_row;
  logic [SW-1:0]  best_sad;

  always #5 clk = ~clk;

  codec_cmm_sad_search_ctrl #(.DW(DW), .W(W), .H(H), .MAX_CAND(MAX_CAND), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cand(num_cand), .abort(abort), .stall(stall),
    .busy(busy), .rd_en(rd_en), .rd_cand(rd_cand), .rd_row(rd_row), .sad_in_vld(sad_in_vld),
    .sad_vld(sad_vld), .sad(sad), .done(done), .best_sad(best_sad), .best_idx(best_idx)
  );

  int passed = 0, total = 0;
  int sads[128];
  int rd_c_q[$], rd_r_q[$];
  int done_cnt, done_iter, last_vld_iter, svl_err, timed_out;
  logic busy_after_start, busy_after_done;
  logic [SW-1:0]  done_best_sad, end_best_sad;
  logic [CIW-1:0] done_best_idx, end_best_idx;
  int last_exp_sad, last_exp_idx;

  // Expected request list is simply every (cand,row) pair in cand-major ascending order.
  function automatic int model_first_row_err(input int n_iss);
    if (rd_c_q.size() != n_iss * H) return -2;
    for (int i = 0; i < n_iss * H; i++)
      if (rd_c_q[i] != i / H || rd_r_q[i] != i % H) return i;
    return -1;
  endfunction

  function automatic void model_best(input int n_iss, output int bsad, output int bidx);
    bsad = (1 << SW) - 1;
    bidx = 0;
    for (int c = 0; c < n_iss; c++)
      if (c == 0 || sads[c] < bsad) begin bsad = sads[c]; bidx = c; end
  endfunction

  task automatic run_search(input int ncand, input int abort_c, input int abort_r, input int stall_c,
                            input int stall_r, input int stall_len, input int stall_pct, input int restart_at);
    bit hist[$];
    int pend_idx[$], pend_t[$];
    int eng_rows = 0, stall_left = 0;
    bit stall_used = 0, abort_used = 0, fin = 0;
    rd_c_q = {}; rd_r_q = {};
    done_cnt = 0; done_iter = -10; last_vld_iter = -10; svl_err = 0; timed_out = 0;
    busy_after_start = 1'b0; busy_after_done = 1'b1;
    hist.push_back(1'b0); hist.push_back(1'b0); hist.push_back(1'b0);
    for (int j = 0; j < 3000 && !fin; j++) begin
      @(posedge clk); #1;
      if (j == 1) busy_after_start = busy;
      if (done_cnt > 0 && j == done_iter + 1) busy_after_done = busy;
      if (done === 1'b1) begin
        done_cnt++; done_iter = j; done_best_sad = best_sad; done_best_idx = best_idx;
      end
      if (sad_in_vld !== hist[j]) svl_err++;
      if (sad_in_vld === 1'b1) begin
        eng_rows++;
        if (eng_rows % H == 0) begin
          pend_idx.push_back(eng_rows / H - 1);
          pend_t.push_back(j + $urandom_range(0, 3));
        end
      end
      if (j >= 1 && busy === 1'b0) fin = 1;
      start = (j == 0) || (j == restart_at);
      num_cand = CNW'(ncand);
      sad_vld = 1'b0;
      sad = SW'($urandom);
      if (pend_idx.size() > 0 && pend_t[0] <= j) begin
        sad_vld = 1'b1;
        sad = SW'(sads[pend_idx[0]]);
        void'(pend_idx.pop_front());
        void'(pend_t.pop_front());
        last_vld_iter = j;
      end
      abort = 1'b0;
      if (!abort_used && abort_c >= 0 && busy === 1'b1 && rd_cand == abort_c && rd_row == abort_r) begin
        abort = 1'b1; abort_used = 1;
      end
      if (!stall_used && stall_c >= 0 && busy === 1'b1 && rd_cand == stall_c && rd_row == stall_r) begin
        stall_used = 1; stall_left = stall_len;
      end
      stall = (stall_left > 0) || ($urandom_range(0, 99) < stall_pct);
      if (stall_left > 0) stall_left--;
      #1;
      hist.push_back(rd_en === 1'b1);
      if (rd_en === 1'b1) begin rd_c_q.push_back(int'(rd_cand)); rd_r_q.push_back(int'(rd_row)); end
    end
    if (!fin) timed_out = 1;
    start = 1'b0; abort = 1'b0; stall = 1'b0; sad_vld = 1'b0;
    end_best_sad = best_sad; end_best_idx = best_idx;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; sad_vld = 1'b0; num_cand = '0; sad = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, rd_en, sad_in_vld, done} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {busy, rd_en, sad_in_vld, done}); else passed++;
    total++; if (best_sad !== '0 || best_idx !== '0)
      $display("[TB] FAIL reset_best: got %0d/%0d, expected 0/0", best_sad, best_idx); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int es, ei, e;
    sads[0] = 300; sads[1] = 120; sads[2] = 120; sads[3] = 500;
    run_search(4, -1, 0, -1, 0, 0, 0, -1);
    model_best(4, es, ei);
    last_exp_sad = es; last_exp_idx = ei;
    e = model_first_row_err(4);
    total++; if (timed_out != 0) $display("[TB] FAIL basic_timeout: got %0d, expected 0", timed_out); else passed++;
    total++; if (e != -1) $display("[TB] FAIL basic_rd_seq: got err %0d (%0d pulses), expected -1", e, rd_c_q.size()); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL basic_done_cnt: got %0d, expected 1", done_cnt); else passed++;
    total++; if (done_best_sad !== SW'(es)) $display("[TB] FAIL basic_best_sad: got %0d, expected %0d", done_best_sad, es); else passed++;
    total++; if (done_best_idx !== CIW'(ei)) $display("[TB] FAIL basic_best_idx: got %0d, expected %0d", done_best_idx, ei); else passed++;
    total++; if (busy_after_start !== 1'b1) $display("[TB] FAIL basic_busy_start: got %b, expected 1", busy_after_start); else passed++;
    total++; if (busy_after_done !== 1'b0) $display("[TB] FAIL basic_busy_after_done: got %b, expected 0", busy_after_done); else passed++;
    total++; if (done_iter != last_vld_iter + 2) $display("[TB] FAIL basic_done_latency: got %0d, expected %0d", done_iter, last_vld_iter + 2); else passed++;
    total++; if (svl_err != 0) $display("[TB] FAIL basic_sad_in_vld: got %0d errors, expected 0", svl_err); else passed++;
  endtask

  task automatic test_stray_idle();
    @(posedge clk); #1;
    sad_vld = 1'b1; sad = '0;
    repeat (2) @(posedge clk);
    #1;
    sad_vld = 1'b0;
    total++; if (best_sad !== SW'(last_exp_sad) || best_idx !== CIW'(last_exp_idx))
      $display("[TB] FAIL stray_idle_best: got %0d/%0d, expected %0d/%0d", best_sad, best_idx, last_exp_sad, last_exp_idx); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL stray_idle_busy: got %b, expected 0", busy); else passed++;
  endtask

  task automatic test_stall();
    int es, ei, e;
    sads[0] = 300; sads[1] = 120; sads[2] = 120; sads[3] = 500;
    run_search(4, -1, 0, 2, 5, 3, 15, -1);
    model_best(4, es, ei);
    e = model_first_row_err(4);
    total++; if (e != -1) $display("[TB] FAIL stall_rd_seq: got err %0d, expected -1", e); else passed++;
    total++; if (svl_err != 0) $display("[TB] FAIL stall_sad_in_vld: got %0d errors, expected 0", svl_err); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL stall_done_cnt: got %0d, expected 1", done_cnt); else passed++;
    total++; if (done_best_sad !== SW'(es) || done_best_idx !== CIW'(ei))
      $display("[TB] FAIL stall_best: got %0d/%0d, expected %0d/%0d", done_best_sad, done_best_idx, es, ei); else passed++;
  endtask

  task automatic test_zero();
    run_search(0, -1, 0, -1, 0, 0, 0, -1);
    total++; if (rd_c_q.size() != 0) $display("[TB] FAIL zero_rd_cnt: got %0d, expected 0", rd_c_q.size()); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL zero_done_cnt: got %0d, expected 1", done_cnt); else passed++;
    total++; if (done_iter < 1 || done_iter > 2) $display("[TB] FAIL zero_done_time: got %0d, expected 1..2", done_iter); else passed++;
    total++; if (done_best_sad !== '1 || done_best_idx !== '0)
      $display("[TB] FAIL zero_best: got %0d/%0d, expected %0d/0", done_best_sad, done_best_idx, (1 << SW) - 1); else passed++;
  endtask

  task automatic test_abort();
    int es, ei, e;
    for (int c = 0; c < 4; c++) sads[c] = $urandom_range(0, (1 << SW) - 2);
    run_search(4, 1, 3, -1, 0, 0, 20, -1);
    model_best(2, es, ei);
    e = model_first_row_err(2);
    total++; if (timed_out != 0) $display("[TB] FAIL abort_timeout: got %0d, expected 0", timed_out); else passed++;
    total++; if (e != -1) $display("[TB] FAIL abort_rd_seq: got err %0d (%0d pulses), expected -1", e, rd_c_q.size()); else passed++;
    total++; if (done_cnt != 0) $display("[TB] FAIL abort_no_done: got %0d, expected 0", done_cnt); else passed++;
    total++; if (end_best_sad !== SW'(es) || end_best_idx !== CIW'(ei))
      $display("[TB] FAIL abort_partial_best: got %0d/%0d, expected %0d/%0d", end_best_sad, end_best_idx, es, ei); else passed++;
  endtask

  task automatic test_overflow();
    int es, ei, e;
    for (int c = 0; c < 128; c++) sads[c] = $urandom_range(0, (1 << SW) - 2);
    run_search(70, -1, 0, -1, 0, 0, 10, 50);
    model_best(MAX_CAND, es, ei);
    e = model_first_row_err(MAX_CAND);
    total++; if (e != -1) $display("[TB] FAIL ovf_rd_seq: got err %0d (%0d pulses), expected -1", e, rd_c_q.size()); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL ovf_done_cnt: got %0d, expected 1", done_cnt); else passed++;
    total++; if (done_best_sad !== SW'(es) || done_best_idx !== CIW'(ei))
      $display("[TB] FAIL ovf_best: got %0d/%0d, expected %0d/%0d", done_best_sad, done_best_idx, es, ei); else passed++;
  endtask

  task automatic test_random();
    int es, ei, e, n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 12);
      for (int c = 0; c < n; c++) sads[c] = $urandom_range(0, 7);
      run_search(n, -1, 0, -1, 0, 0, 30, -1);
      model_best(n, es, ei);
      e = model_first_row_err(n);
      total++; if (e != -1) $display("[TB] FAIL rand%0d_rd_seq: got err %0d, expected -1", k, e); else passed++;
      total++; if (done_cnt != 1 || done_iter != last_vld_iter + 2)
        $display("[TB] FAIL rand%0d_done: got cnt %0d at %0d, expected 1 at %0d", k, done_cnt, done_iter, last_vld_iter + 2); else passed++;
      total++; if (done_best_sad !== SW'(es) || done_best_idx !== CIW'(ei))
        $display("[TB] FAIL rand%0d_best: got %0d/%0d, expected %0d/%0d", k, done_best_sad, done_best_idx, es, ei); else passed++;
      total++; if (svl_err != 0) $display("[TB] FAIL rand%0d_sad_in_vld: got %0d errors, expected 0", k, svl_err); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; num_cand = CNW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (rd_en !== 1'b1) $display("[TB] FAIL rstmid_issuing: got %b, expected 1", rd_en); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, rd_en, sad_in_vld, done} !== 4'b0000)
      $display("[TB] FAIL rstmid_ctrl: got %b, expected 0000", {busy, rd_en, sad_in_vld, done}); else passed++;
    total++; if (best_sad !== '0 || best_idx !== '0)
      $display("[TB] FAIL rstmid_best: got %0d/%0d, expected 0/0", best_sad, best_idx); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int es, ei, e;
    for (int k = 2; k <= 3; k++) begin
      for (int c = 0; c < k; c++) sads[c] = $urandom_range(0, (1 << SW) - 2);
      run_search(k, -1, 0, -1, 0, 0, 0, -1);
      model_best(k, es, ei);
      e = model_first_row_err(k);
      total++; if (e != -1 || done_cnt != 1)
        $display("[TB] FAIL b2b%0d_seq_done: got err %0d done %0d, expected -1 and 1", k, e, done_cnt); else passed++;
      total++; if (done_best_sad !== SW'(es) || done_best_idx !== CIW'(ei))
        $display("[TB] FAIL b2b%0d_best: got %0d/%0d, expected %0d/%0d", k, done_best_sad, done_best_idx, es, ei); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stray_idle();
    test_stall();
    test_zero();
    test_abort();
    test_overflow();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
